// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared opcodes, FSM encoding, error bits and CRC polynomials
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // Polynomials without the implicit top term: x^4+x+1 and x^3+x+1.
  localparam logic [3:0] CRC4_POLY = 4'b0011;
  localparam logic [2:0] CRC3_POLY = 3'b011;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_crc.sv
// rtl/mtm_alu_crc.sv - combinational MSB-first CRC, zero initial value
module mtm_alu_crc #(
  parameter int               DIN_W = 68,
  parameter int               CRC_W = 4,
  parameter logic [CRC_W-1:0] POLY  = '0
) (
  input  logic [DIN_W-1:0] data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_v;
  logic             fb;

  always_comb begin
    crc_v = '0;
    fb    = 1'b0;
    for (int i = DIN_W - 1; i >= 0; i--) begin
      fb    = crc_v[CRC_W-1] ^ data_i[i];
      crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/mtm_alu_ctrl.sv
// rtl/mtm_alu_ctrl.sv - request validation, core sequencing and response framing
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic [2:0]        in_op,
  input  logic [3:0]        in_crc,
  input  logic              in_err_data,
  output logic [DATA_W-1:0] core_A,
  output logic [DATA_W-1:0] core_B,
  output logic [2:0]        core_op,
  input  logic [DATA_W-1:0] core_C,
  input  logic              core_carry,
  input  logic              core_overflow,
  input  logic              core_zero,
  input  logic              core_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_C,
  output logic [7:0]        out_ctl
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        crc_q, crc_d;
  logic              errd_q, errd_d;
  logic [7:0]        ctl_q, ctl_d;
  logic [3:0]        crc4_calc;
  logic [2:0]        crc3_calc;
  logic [3:0]        flags;
  logic [2:0]        err;

  assign flags = {core_carry, core_overflow, core_zero, core_negative};

  mtm_alu_crc #(.DIN_W(2*DATA_W+4), .CRC_W(4), .POLY(CRC4_POLY)) u_crc4 (
    .data_i ({b_q, a_q, 1'b1, op_q}),
    .crc_o  (crc4_calc)
  );

  mtm_alu_crc #(.DIN_W(DATA_W+5), .CRC_W(3), .POLY(CRC3_POLY)) u_crc3 (
    .data_i ({core_C, 1'b0, flags}),
    .crc_o  (crc3_calc)
  );

  // Priority encode so exactly one error bit is ever reported.
  always_comb begin
    err = '0;
    if (errd_q)                  err[ERR_DATA_BIT] = 1'b1;
    else if (crc4_calc != crc_q) err[ERR_CRC_BIT]  = 1'b1;
    else if (!op_is_valid(op_q)) err[ERR_OP_BIT]   = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    crc_d     = crc_q;
    errd_d    = errd_q;
    res_d     = res_q;
    ctl_d     = ctl_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_A;
          b_d     = in_B;
          op_d    = in_op;
          crc_d   = in_crc;
          errd_d  = in_err_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (|err) begin
          res_d   = '0;
          ctl_d   = {1'b1, err, err, ^{1'b1, err, err}};
          state_d = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = core_C;
        ctl_d   = {1'b0, flags, crc3_calc};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      crc_q   <= '0;
      errd_q  <= 1'b0;
      res_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      crc_q   <= crc_d;
      errd_q  <= errd_d;
      res_q   <= res_d;
      ctl_q   <= ctl_d;
    end
  end

  assign core_A  = a_q;
  assign core_B  = b_q;
  assign core_op = op_q;
  assign out_C   = res_q;
  assign out_ctl = ctl_q;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb/tb_mtm_alu_ctrl.sv - randomized self-checking bench for mtm_alu_ctrl
module tb_mtm_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_err_data;
  logic [31:0] in_A, in_B;
  logic [2:0]  in_op;
  logic [3:0]  in_crc;
  logic [31:0] core_A, core_B, core_C;
  logic [2:0]  core_op;
  logic        core_carry, core_overflow, core_zero, core_negative;
  logic        out_valid, out_ready;
  logic [31:0] out_C;
  logic [7:0]  out_ctl;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] obs_C;
  logic [7:0]  obs_ctl;

  always #5 clk = ~clk;

  mtm_alu_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_op(in_op), .in_crc(in_crc), .in_err_data(in_err_data),
    .core_A(core_A), .core_B(core_B), .core_op(core_op),
    .core_C(core_C), .core_carry(core_carry), .core_overflow(core_overflow),
    .core_zero(core_zero), .core_negative(core_negative),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_C(out_C), .out_ctl(out_ctl)
  );

  // Behavioural ALU: returns {C, carry, overflow, zero, negative}.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] c;
    logic        cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    s  = '0;
    case (op)
      3'b000: c = a & b;
      3'b001: c = a | b;
      3'b100: begin
        s  = {1'b0, a} + {1'b0, b};
        c  = s[31:0];
        cy = s[32];
        ov = (a[31] == b[31]) && (c[31] != a[31]);
      end
      3'b101: begin
        c  = a - b;
        cy = (a < b);
        ov = (a[31] != b[31]) && (c[31] != a[31]);
      end
      default: c = '0;
    endcase
    return {c, cy, ov, (c == 32'd0), c[31]};
  endfunction

  assign {core_C, core_carry, core_overflow, core_zero, core_negative} = alu_model(core_A, core_B, core_op);

  // CRC as the remainder of msg * x^n divided by the generator polynomial.
  function automatic logic [3:0] crc_div(input logic [127:0] msg, input int len, input int n, input logic [127:0] gen);
    logic [127:0] r;
    r = msg << n;
    for (int i = len + n - 1; i >= n; i--)
      if (r[i]) r = r ^ (gen << (i - n));
    return r[3:0];
  endfunction

  function automatic logic [3:0] crc4_of(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [127:0] m;
    m = 128'({b, a, 1'b1, op});
    return crc_div(m, 68, 4, 128'h13);
  endfunction

  function automatic logic [2:0] crc3_of(input logic [31:0] c, input logic [3:0] f);
    logic [127:0] m;
    logic [3:0]   r;
    m = 128'({c, 1'b0, f});
    r = crc_div(m, 37, 3, 128'hB);
    return r[2:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [3:0] crc, input logic errd, input int stall);
    logic [2:0]  e;
    logic [6:0]  top7;
    logic [35:0] r;
    logic [31:0] exp_c;
    logic [7:0]  exp_ctl;
    int          exp_lat, lat;
    bit          is_ok;
    e = 3'b000;
    if (errd) e = 3'b100;
    else if (crc != crc4_of(a, b, op)) e = 3'b010;
    else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) e = 3'b001;
    is_ok = (e == 3'b000);
    if (is_ok) begin
      r       = alu_model(a, b, op);
      exp_c   = r[35:4];
      exp_ctl = {1'b0, r[3:0], crc3_of(r[35:4], r[3:0])};
      exp_lat = 3;
    end else begin
      top7    = {1'b1, e, e};
      exp_c   = '0;
      exp_ctl = {top7, 1'($countones(top7) % 2)};
      exp_lat = 2;
    end

    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_A = a; in_B = b; in_op = op; in_crc = crc; in_err_data = errd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_A = $urandom; in_B = $urandom; in_err_data = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("out_C", 64'(out_C), 64'(exp_c));
    chk("out_ctl", 64'(out_ctl), 64'(exp_ctl));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    if (!errd) chk("core_regs", {core_A, core_B}, {a, b});
    obs_C   = out_C;
    obs_ctl = out_ctl;

    for (int s = 0; s < stall; s++) begin
      if (s == 1) begin
        in_valid = 1'b1; in_A = $urandom; in_op = 3'b100;
      end
      @(negedge clk);
      chk("stall_hold", {27'd0, out_valid, in_ready, out_ctl, out_C}, {27'd0, 1'b1, 1'b0, exp_ctl, exp_c});
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_done", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [3:0]  rcrc;
    bit          quiet;

    rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_op = '0; in_crc = '0;
    in_err_data = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_state", {out_valid, in_ready, out_ctl, out_C, core_op},
        {1'b0, 1'b1, 8'h00, 32'h0, 3'b000});
    chk("reset_core", {core_A, core_B}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(32'd1, 32'd2, 3'b100, crc4_of(32'd1, 32'd2, 3'b100), 1'b0, 0);
    chk("add_1_2_C", 64'(obs_C), 64'h3);
    chk("add_1_2_flags", 64'(obs_ctl[7:3]), 64'd0);

    run_txn(32'hFFFF_FFFF, 32'd1, 3'b100, crc4_of(32'hFFFF_FFFF, 32'd1, 3'b100), 1'b0, 0);
    chk("add_wrap", {61'd0, obs_ctl[7], obs_ctl[6], obs_ctl[4]}, {61'd0, 1'b0, 1'b1, 1'b1});
    chk("add_wrap_C", 64'(obs_C), 64'd0);

    run_txn(32'h1234_5678, 32'h0F0F_0F0F, 3'b000,
            crc4_of(32'h1234_5678, 32'h0F0F_0F0F, 3'b000) ^ 4'h1, 1'b0, 0);
    chk("err_crc_ctl", 64'(obs_ctl), 64'hA5);

    run_txn(32'hA5A5_0001, 32'h0000_0007, 3'b010, crc4_of(32'hA5A5_0001, 32'h0000_0007, 3'b010), 1'b0, 0);
    chk("err_op_ctl", 64'(obs_ctl), 64'h93);

    run_txn(32'hA5A5_0001, 32'h0000_0007, 3'b010,
            crc4_of(32'hA5A5_0001, 32'h0000_0007, 3'b010) ^ 4'h6, 1'b1, 0);
    chk("err_data_ctl", 64'(obs_ctl), 64'hC9);

    run_txn(32'h8000_0000, 32'h0000_0001, 3'b101, crc4_of(32'h8000_0000, 32'h0000_0001, 3'b101), 1'b0, 10);

    // Reset pulse while the transaction sits in EXEC.
    @(negedge clk);
    in_valid = 1'b1; in_A = 32'd5; in_B = 32'd7; in_op = 3'b100; in_crc = crc4_of(32'd5, 32'd7, 3'b100);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", {out_valid, in_ready, out_ctl, out_C}, {1'b0, 1'b1, 8'h00, 32'h0});
    chk("midreset_core", {29'd0, core_op, core_A}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("midreset_no_resp", 64'(quiet), 64'd1);
    run_txn(32'd5, 32'd7, 3'b100, crc4_of(32'd5, 32'd7, 3'b100), 1'b0, 0);
    chk("post_reset_C", 64'(obs_C), 64'd12);

    for (int t = 0; t < 40; t++) begin
      ra   = $urandom;
      rb   = (t % 5 == 0) ? ra : $urandom;
      rop  = 3'($urandom_range(0, 7));
      rcrc = crc4_of(ra, rb, rop);
      if ($urandom_range(0, 3) == 0) rcrc = rcrc ^ 4'($urandom_range(1, 15));
      run_txn(ra, rb, rop, rcrc, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
